// File: rtl/activation_pkg.sv
// Shared definitions for the activation datapath: mode encodings and the
// helpers that place the output slice and overflow window in the wide sum.
package activation_pkg;

  typedef enum logic [1:0] {
    ACT_RELU   = 2'd0,
    ACT_LEAKY  = 2'd1,
    ACT_LINEAR = 2'd2,
    ACT_RSVD   = 2'd3
  } act_mode_e;

  // MSB of the dataWidth-bit output slice inside the (2*dataWidth+1)-bit value
  function automatic int slice_msb(input int dw, input int wi);
    return 2 * dw - 1 - wi;
  endfunction

  // Window from the extended sign bit down to the slice MSB, inclusive
  function automatic int win_w(input int wi);
    return wi + 2;
  endfunction

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_WINT_W    = 4;
  localparam int DEF_SLICE_MSB = slice_msb(DEF_DATA_W, DEF_WINT_W);
  localparam int DEF_WIN_W     = win_w(DEF_WINT_W);

endpackage

// File: rtl/act_saturate.sv
// Narrowing stage: extracts the dataWidth output slice from a sign-extended
// wide value and clamps to the signed limits when the integer part overflows.
module act_saturate
  import activation_pkg::*;
#(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4
) (
  input  logic signed [2*dataWidth:0]  y,
  output logic signed [dataWidth-1:0]  data,
  output logic                         sat
);

  localparam int SMSB = slice_msb(dataWidth, weightIntWidth);
  localparam int WW   = win_w(weightIntWidth);

  logic [WW-1:0] win;
  logic          ovf;
  logic          unused_lsb;

  assign win        = y[2*dataWidth -: WW];
  assign ovf        = !((&win) || !(|win));
  // Fraction bits below the slice are dropped (floor)
  assign unused_lsb = ^y[SMSB-dataWidth:0];

  always_comb begin
    sat  = ovf;
    data = y[SMSB -: dataWidth];
    if (ovf) begin
      data = y[2*dataWidth] ? {1'b1, {(dataWidth-1){1'b0}}}
                            : {1'b0, {(dataWidth-1){1'b1}}};
    end
  end

endmodule

// File: rtl/activation_unit.sv
// Two-stage activation (ReLU / leaky / linear) with valid/ready backpressure
// and saturation counting. Define ACT_ROUND_NEAREST_EN for round-half-up.
module activation_unit
  import activation_pkg::*;
#(
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4,
  parameter int LEAK_SHIFT     = 3,
  parameter int CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [2*dataWidth-1:0] in_data,
  input  logic [1:0]                    in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [dataWidth-1:0]   out_data,
  output logic                          out_sat,
  output logic [CNT_W-1:0]              sat_cnt,
  input  logic                          sat_cnt_clr
);

  localparam int YW = 2 * dataWidth + 1;

  function automatic logic signed [YW-1:0] activate(
    input logic signed [2*dataWidth-1:0] x,
    input logic [1:0]                    mode
  );
    logic signed [YW-1:0] xs;
    xs = {x[2*dataWidth-1], x};
    case (act_mode_e'(mode))
      ACT_LEAKY:  return x[2*dataWidth-1] ? (xs >>> LEAK_SHIFT) : xs;
      ACT_LINEAR: return xs;
      default:    return x[2*dataWidth-1] ? '0 : xs;
    endcase
  endfunction

`ifdef ACT_ROUND_NEAREST_EN
  localparam logic signed [YW-1:0] RND_HALF =
    YW'(1) << (dataWidth - weightIntWidth - 1);

  // The extra MSB absorbs the carry, which then lands in the overflow window
  function automatic logic signed [YW-1:0] round_y(input logic signed [YW-1:0] y);
    return y + RND_HALF;
  endfunction
`else
  function automatic logic signed [YW-1:0] round_y(input logic signed [YW-1:0] y);
    return y;
  endfunction
`endif

  logic                        en;
  logic                        vld_p1;
  logic signed [YW-1:0]        y_p1;
  logic signed [dataWidth-1:0] sat_data;
  logic                        sat_flag;
  logic                        vld_p2;
  logic signed [dataWidth-1:0] data_p2;
  logic                        sat_p2;

  assign en       = !vld_p2 || out_ready;
  assign in_ready = en;

  // Stage 1: mode processing (mode travels with its sample)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else if (en) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en && in_valid) y_p1 <= round_y(activate(in_data, in_mode));
  end

  act_saturate #(
    .dataWidth     (dataWidth),
    .weightIntWidth(weightIntWidth)
  ) u_sat (
    .y   (y_p1),
    .data(sat_data),
    .sat (sat_flag)
  );

  // Stage 2: slice/clamp result registered as the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sat_p2  <= 1'b0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= sat_data;
        sat_p2  <= sat_flag;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_sat   = sat_p2;

  // Counts clamped samples actually taken downstream; sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_cnt <= '0;
    else if (sat_cnt_clr) sat_cnt <= '0;
    else if (vld_p2 && out_ready && sat_p2 && !(&sat_cnt)) sat_cnt <= sat_cnt + 1'b1;
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit: vector table plus backpressure,
// counter, reset and narrow-counter sequences.
module tb_activation_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sat;
  logic [15:0] sat_cnt;
  logic        sat_cnt_clr = 1'b0;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [31:0] in_data2 = '0;
  logic [1:0]  in_mode2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [15:0] out_data2;
  logic        out_sat2;
  logic [1:0]  sat_cnt2;
  logic        sat_cnt_clr2 = 1'b0;

  always #5 clk = ~clk;

  activation_unit #(.dataWidth(16), .weightIntWidth(4), .LEAK_SHIFT(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
  );

  activation_unit #(.dataWidth(16), .weightIntWidth(4), .LEAK_SHIFT(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_mode(in_mode2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .out_sat(out_sat2),
    .sat_cnt(sat_cnt2), .sat_cnt_clr(sat_cnt_clr2)
  );

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [31:0] data;
    logic [15:0] exp;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          exp_sats;
    int          sent;
    int          received;
    bit          prev_stall;
    logic [15:0] prev_data;
    bit          fire_in;
    bit          fire_out;
    bit          pat[4];

    vecs.push_back('{"relu_pos",     2'd0, 32'h00123000, 16'h0123, 1'b0});
    vecs.push_back('{"relu_ovf",     2'd0, 32'h08000000, 16'h7FFF, 1'b1});
    vecs.push_back('{"relu_neg",     2'd0, 32'hFFFFF000, 16'h0000, 1'b0});
    vecs.push_back('{"relu_minneg",  2'd0, 32'h80000000, 16'h0000, 1'b0});
    vecs.push_back('{"leaky_neg",    2'd1, 32'hFFF00000, 16'hFFE0, 1'b0});
    vecs.push_back('{"leaky_pos",    2'd1, 32'h00123000, 16'h0123, 1'b0});
    vecs.push_back('{"lin_negovf",   2'd2, 32'h80000000, 16'h8000, 1'b1});
    vecs.push_back('{"lin_neg",      2'd2, 32'hFFFFF000, 16'hFFFF, 1'b0});
    vecs.push_back('{"rsvd_as_relu", 2'd3, 32'hFFFFF000, 16'h0000, 1'b0});
`ifdef ACT_ROUND_NEAREST_EN
    vecs.push_back('{"rnd_half",     2'd2, 32'h00000800, 16'h0001, 1'b0});
    vecs.push_back('{"rnd_carry",    2'd2, 32'h07FFF800, 16'h7FFF, 1'b1});
`else
    vecs.push_back('{"rnd_half",     2'd2, 32'h00000800, 16'h0000, 1'b0});
    vecs.push_back('{"rnd_carry",    2'd2, 32'h07FFF800, 16'h7FFF, 1'b0});
`endif

    // Reset state
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    chk("rst_sat_cnt",   32'(sat_cnt),   32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Vector table, one sample at a time with 2-cycle latency
    exp_sats = 0;
    foreach (vecs[i]) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      in_mode  = vecs[i].mode;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      in_mode  = 2'd2;
      chk({vecs[i].name, "_lat1"}, 32'(out_valid), 32'd0);
      tick();
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      chk({vecs[i].name, "_data"},  32'(out_data),  32'(vecs[i].exp));
      chk({vecs[i].name, "_sat"},   32'(out_sat),   32'(vecs[i].exp_sat));
      if (vecs[i].exp_sat) exp_sats++;
    end
    tick();
    chk("table_sat_cnt", 32'(sat_cnt), 32'(exp_sats));

    // Counter: clear, then three saturating transfers
    sat_cnt_clr = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    chk("cnt_clear", 32'(sat_cnt), 32'd0);
    in_valid = 1'b1; in_data = 32'h80000000; in_mode = 2'd2;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("cnt_three", 32'(sat_cnt), 32'd3);

    // Clear coincident with a saturating transfer
    in_valid = 1'b1; in_data = 32'h08000000; in_mode = 2'd0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_pending_sat", 32'(out_valid && out_sat), 32'd1);
    sat_cnt_clr = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    chk("clr_priority", 32'(sat_cnt), 32'd0);
    tick();

    // Backpressure stream of 8 samples, out_ready pattern 1,0,0,1
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; received = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && received < 8; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_data   = 32'(sent + 1) << 12;
      in_mode   = 2'd2;
      #1;
      if (prev_stall) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data",  32'(out_data),  32'(prev_data));
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        chk("bp_order", 32'(out_data), 32'(received + 1));
        received++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(posedge clk);
      #1;
      if (fire_in) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(received), 32'd8);
    repeat (3) tick();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Reset with two samples in flight
    in_valid = 1'b1; in_data = 32'h00123000; in_mode = 2'd0;
    tick();
    in_data = 32'h00456000;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_data",  32'(out_data),  32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Narrow counter saturates at all-ones
    in_valid2 = 1'b1; in_data2 = 32'h80000000; in_mode2 = 2'd2;
    repeat (5) tick();
    in_valid2 = 1'b0;
    repeat (4) tick();
    chk("cnt2_hold", 32'(sat_cnt2), 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
